// File: rtl/rv32_m_issue_pkg.sv
// Shared RV32 M-extension types: XLEN, funct3 op encoding and the issue-stage
// FSM state encoding used by rv32_m_issue.
package pkg_rv32_types;

    localparam int unsigned XLEN                 = 32;
    localparam int unsigned M_DIV_CYCLES_DEFAULT = 4;
    localparam int unsigned M_CNT_W              = 4;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_e;

    typedef enum logic [1:0] {
        M_ISS_IDLE = 2'd0,
        M_ISS_EXEC = 2'd1,
        M_ISS_RESP = 2'd2
    } m_iss_state_e;

    // funct3 bit 2 separates the divide/remainder group from the multiplies.
    function automatic logic m_op_is_div(input m_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/rv32_m_issue.sv
// Issue/hold stage in front of the combinational M-extension datapath.
// Define M_DIV_MULTICYCLE_EN to give divide/remainder ops DIV_CYCLES EXEC cycles.
module rv32_m_issue
    import pkg_rv32_types::*;
#(
    parameter int unsigned DIV_CYCLES = M_DIV_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  m_op_e           req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            m_valid,
    output m_op_e           m_op,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] m_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            busy
);

    if (DIV_CYCLES == 0 || DIV_CYCLES > 16) begin : g_div_cycles_range
        $error("rv32_m_issue: DIV_CYCLES must be in 1..16");
    end

    m_iss_state_e    state_q, state_d;
    m_op_e           op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic [4:0]      rsp_rd_q, rsp_rd_d;
    logic            idle_q, idle_d;
    logic            m_valid_q, m_valid_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic            last_exec;

`ifdef M_DIV_MULTICYCLE_EN
    localparam logic [M_CNT_W-1:0] DIV_LAST = M_CNT_W'(DIV_CYCLES - 1);

    logic [M_CNT_W-1:0] cnt_q, cnt_d;

    assign last_exec = (cnt_q == '0);
`else
    assign last_exec = 1'b1;
`endif

    // idle_q is cleared by reset, so req_ready stays low until the first edge after release.
    assign req_ready = idle_q && !flush;
    assign m_valid   = m_valid_q;
    assign m_op      = op_q;
    assign operand_a = a_q;
    assign operand_b = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
`ifdef M_DIV_MULTICYCLE_EN
        cnt_d      = cnt_q;
`endif

        if (flush) begin
            state_d = M_ISS_IDLE;
        end else begin
            case (state_q)
                M_ISS_IDLE: begin
                    if (req_valid && req_ready) begin
                        state_d = M_ISS_EXEC;
                        op_d    = req_op;
                        a_d     = req_rs1;
                        b_d     = req_rs2;
                        rd_d    = req_rd;
`ifdef M_DIV_MULTICYCLE_EN
                        cnt_d   = m_op_is_div(req_op) ? DIV_LAST : '0;
`endif
                    end
                end
                M_ISS_EXEC: begin
`ifdef M_DIV_MULTICYCLE_EN
                    cnt_d = cnt_q - M_CNT_W'(1);
`endif
                    if (last_exec) begin
                        state_d    = M_ISS_RESP;
                        rsp_data_d = m_result;
                        rsp_rd_d   = rd_q;
                    end
                end
                M_ISS_RESP: begin
                    if (rsp_ready) begin
                        state_d = M_ISS_IDLE;
                    end
                end
                default: begin
                    state_d = M_ISS_IDLE;
                end
            endcase
        end

        idle_d      = (state_d == M_ISS_IDLE);
        m_valid_d   = (state_d == M_ISS_EXEC);
        rsp_valid_d = (state_d == M_ISS_RESP);
        busy_d      = (state_d != M_ISS_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= M_ISS_IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            idle_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef M_DIV_MULTICYCLE_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            idle_q      <= idle_d;
            m_valid_q   <= m_valid_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef M_DIV_MULTICYCLE_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rv32_m_issue.sv
// Directed bench for rv32_m_issue: cycle-level transaction model plus literal expectations.
module tb_rv32_m_issue;
    import pkg_rv32_types::*;

    localparam int unsigned DIVC = 4;
`ifdef M_DIV_MULTICYCLE_EN
    localparam bit DIV_MC = 1'b1;
`else
    localparam bit DIV_MC = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    m_op_e       req_op    = OP_MUL;
    logic [31:0] req_rs1   = '0;
    logic [31:0] req_rs2   = '0;
    logic [4:0]  req_rd    = '0;
    logic        flush     = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, m_valid, rsp_valid, busy;
    m_op_e       m_op;
    logic [31:0] operand_a, operand_b, m_result, rsp_data;
    logic [4:0]  rsp_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_m_issue #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
        .m_valid(m_valid), .m_op(m_op), .operand_a(operand_a), .operand_b(operand_b),
        .m_result(m_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .busy(busy)
    );

    // Reference RV32M arithmetic; also serves as the parent's combinational datapath.
    function automatic logic [31:0] mext(input m_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub;          r = p[31:0];  end
            OP_MULH:   begin p = sa * sb;          r = p[63:32]; end
            OP_MULHSU: begin p = sa * $signed(ub); r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub;          r = p[63:32]; end
            OP_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
            end
            OP_REMU: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign m_result = mext(m_op, operand_a, operand_b);

    function automatic int exp_lat(input m_op_e op);
        return (DIV_MC && (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})) ? int'(DIVC) : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one op in flight, timed by accept cycle and latency.
    int          cyc = 0;
    bit          ready_ok = 1'b0;
    bit          in_flight = 1'b0;
    int          st = 0;
    int          lat = 1;
    m_op_e       mo = OP_MUL;
    logic [31:0] ma = '0, mb = '0, md = '0;
    logic [4:0]  mrd = '0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight = 1'b0;
            ready_ok  = 1'b0;
            last_data = '0;
            last_rd   = '0;
        end else begin
            int prev;
            prev = cyc;
            cyc  = cyc + 1;
            if (flush) begin
                in_flight = 1'b0;
            end else if (in_flight) begin
                if (prev >= st + lat && rsp_ready) in_flight = 1'b0;
            end else if (ready_ok && req_valid) begin
                in_flight = 1'b1;
                st  = cyc;
                lat = exp_lat(req_op);
                mo  = req_op;
                ma  = req_rs1;
                mb  = req_rs2;
                mrd = req_rd;
                md  = mext(req_op, req_rs1, req_rs2);
            end
            if (in_flight && cyc == st + lat) begin
                last_data = md;
                last_rd   = mrd;
            end
            ready_ok = 1'b1;
        end
    end

    always @(posedge clk) begin
        bit exp_mv, exp_rv;
        #1;
        exp_mv = in_flight && (cyc < st + lat);
        exp_rv = in_flight && (cyc >= st + lat);
        chk("req_ready", req_ready, ready_ok && !in_flight && !flush);
        chk("m_valid", m_valid, exp_mv);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("busy", busy, in_flight);
        chk("rsp_data", rsp_data, last_data);
        chk("rsp_rd", rsp_rd, last_rd);
        if (exp_mv) begin
            chk("m_op", m_op, mo);
            chk("operand_a", operand_a, ma);
            chk("operand_b", operand_b, mb);
        end
    end

    task automatic run_op(input string nm, input m_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int stall);
        int n, acc, mv, el;
        bit got;
        el = exp_lat(op);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        rsp_ready = (stall == 0);
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        mv = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (m_valid) mv++;
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk({nm, "_rsp_seen"}, got, 1'b1);
        chk({nm, "_data"}, rsp_data, exp);
        chk({nm, "_rd"}, rsp_rd, rd);
        chk({nm, "_latency"}, cyc - acc, el);
        chk({nm, "_mvalid_cycles"}, mv, el);
        for (int s = 0; s < stall; s++) begin
            chk({nm, "_stall_valid"}, rsp_valid, 1'b1);
            chk({nm, "_stall_ready"}, req_ready, 1'b0);
            chk({nm, "_stall_busy"}, busy, 1'b1);
            chk({nm, "_stall_data"}, rsp_data, exp);
            @(posedge clk); #1;
        end
        if (stall > 0) chk({nm, "_stall_last"}, rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done_valid"}, rsp_valid, 1'b0);
        chk({nm, "_done_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got running want finished)");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel_ready_before_edge", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("rel_ready_first_cycle", req_ready, 1'b1);

        run_op("mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
        run_op("mulh",   OP_MULH,   32'd2,          32'h8000_0000, 5'd6,  32'hFFFF_FFFF, 0);
        run_op("mulhsu", OP_MULHSU, 32'd2,          32'h8000_0000, 5'd7,  32'h0000_0001, 0);
        run_op("mulhu",  OP_MULHU,  32'h8000_0000,  32'd4,         5'd8,  32'h0000_0002, 0);
        run_op("div",    OP_DIV,    32'd100,        32'd7,         5'd9,  32'd14,        0);
        run_op("divneg", OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 0);
        run_op("divu0",  OP_DIVU,   32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 0);
        run_op("remneg", OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFF, 0);
        run_op("remu",   OP_REMU,   32'd100,        32'd7,         5'd13, 32'd2,         0);
        run_op("rem0",   OP_REM,    32'd9,          32'd0,         5'd14, 32'd9,         0);
        run_op("divovf", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
        run_op("removf", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0,         0);
        run_op("mulhu_stall", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE, 3);
        run_op("rd0",    OP_MUL,    32'd3,          32'd4,         5'd0,  32'd12,        0);

        // Flush during the second cycle after accepting a REM.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_REM; req_rs1 = 32'd50; req_rs2 = 32'd7; req_rd = 5'd3;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("flush_accepted", busy, 1'b1);
        @(posedge clk);
        @(negedge clk); flush = 1'b1; #1;
        chk("flush_in_exec", m_valid, DIV_MC);
        chk("flush_req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("flush_busy", busy, 1'b0);
        chk("flush_rsp_valid", rsp_valid, 1'b0);
        flush = 1'b0; #1;
        chk("flush_idle_ready", req_ready, 1'b1);

        // Flush and request in the same cycle: nothing accepted.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MUL; req_rs1 = 32'd11; req_rs2 = 32'd13; req_rd = 5'd4;
        flush = 1'b1; #1;
        chk("flushreq_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("flushreq_busy", busy, 1'b0);
        req_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);

        // Asynchronous reset while an op is executing.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIV; req_rs1 = 32'd100; req_rs2 = 32'd7; req_rd = 5'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstx_in_exec", m_valid, 1'b1);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rstx_m_valid", m_valid, 1'b0);
        chk("rstx_busy", busy, 1'b0);
        chk("rstx_rsp_valid", rsp_valid, 1'b0);
        chk("rstx_req_ready", req_ready, 1'b0);
        chk("rstx_rsp_data", rsp_data, 32'h0);
        chk("rstx_operand_a", operand_a, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; #1;
        chk("rstx_ready_before_edge", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("rstx_ready_after", req_ready, 1'b1);
        repeat (6) @(posedge clk);

        run_op("post_rst", OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd31, 32'h0, 0);

        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
